// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the render block.
// The generator drives it through master; consumers read it through slave.
interface vga_timing_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       bright;
    logic       hSync;
    logic       vSync;
    logic       pix_en;
    logic       line_start;
    logic       frame_start;

    modport master (
        output hCount,
        output vCount,
        output bright,
        output hSync,
        output vSync,
        output pix_en,
        output line_start,
        output frame_start
    );

    modport slave (
        input hCount,
        input vCount,
        input bright,
        input hSync,
        input vSync,
        input pix_en,
        input line_start,
        input frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider to a pixel enable, h/v counters,
// registered sync/blank decode and line/frame strobes.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HS_END   = 10'(H_SYNC);
    localparam logic [9:0]    VS_END   = 10'(V_SYNC);
    localparam logic [9:0]    HA_BEG   = 10'(H_ACT_START);
    localparam logic [9:0]    HA_END   = 10'(H_ACT_END);
    localparam logic [9:0]    VA_BEG   = 10'(V_ACT_START);
    localparam logic [9:0]    VA_END   = 10'(V_ACT_END);

    logic [DW-1:0] div;
    logic          step;
    logic          h_wrap;
    logic          v_wrap;
    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          h_vis;
    logic          v_vis;

    // With CLK_DIV=1 every clk is a pixel step and div stays at 0.
    always_comb begin
        step   = (CLK_DIV == 1) || (div == DIV_LAST);
        h_wrap = (vga.hCount == H_LAST);
        v_wrap = (vga.vCount == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : vga.hCount + 10'd1;
        v_nxt  = vga.vCount;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : vga.vCount + 10'd1;
        end
        h_vis  = (h_nxt >= HA_BEG) && (h_nxt < HA_END);
        v_vis  = (v_nxt >= VA_BEG) && (v_nxt < VA_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (step) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Decode from next-state counts so every output lands with its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.hCount      <= '0;
            vga.vCount      <= '0;
            vga.bright      <= 1'b0;
            vga.hSync       <= 1'b0;
            vga.vSync       <= 1'b0;
            vga.pix_en      <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pix_en <= step;
            if (step) begin
                vga.hCount      <= h_nxt;
                vga.vCount      <= v_nxt;
                vga.hSync       <= (h_nxt >= HS_END);
                vga.vSync       <= (v_nxt >= VS_END);
                vga.bright      <= h_vis && v_vis;
                vga.line_start  <= h_wrap;
                vga.frame_start <= h_wrap && v_wrap;
            end else begin
                vga.line_start  <= 1'b0;
                vga.frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 timing at CLK_DIV=4 plus a shrunken
// raster at CLK_DIV=1 so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic rst_s;

    int n_chk;
    int n_err;

    vga_timing_if vb ();
    vga_timing_if vs ();

    vga_timing_gen u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vb)
    );

    vga_timing_gen #(
        .CLK_DIV     (1),
        .H_TOTAL     (20),
        .H_SYNC      (3),
        .H_ACT_START (5),
        .H_ACT_END   (17),
        .V_TOTAL     (10),
        .V_SYNC      (2),
        .V_ACT_START (3),
        .V_ACT_END   (8)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_s),
        .vga   (vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges from now until the big DUT shows pix_en (bounded).
    task automatic next_pe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vb.pix_en && n < 40);
    endtask

    task automatic first_pe_after_release(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (!vb.pix_en) begin
                check({tag, "_early_ls"}, int'(vb.line_start), 0);
            end
        end while (!vb.pix_en && n < 40);
        check({tag, "_first_pe_edge"}, n, 4);
        check({tag, "_first_h"}, int'(vb.hCount), 1);
        check({tag, "_first_v"}, int'(vb.vCount), 0);
        check({tag, "_first_ls"}, int'(vb.line_start), 0);
        tick();
        check({tag, "_pe_width"}, int'(vb.pix_en), 0);
        next_pe(n);
        check({tag, "_pe_gap"}, n + 1, 4);
        check({tag, "_second_h"}, int'(vb.hCount), 2);
    endtask

    initial begin
        int n;
        int hs_lo;
        int pe_cnt;
        int br_cnt;
        int vs_lo;
        int ls_cnt;
        int pe_zero;
        logic [7:0] bpt;
        logic [1:0] hpt;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        rst_s = 1'b0;

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_h", int'(vb.hCount), 0);
        check("rst_v", int'(vb.vCount), 0);
        check("rst_pe", int'(vb.pix_en), 0);
        check("rst_bright", int'(vb.bright), 0);
        check("rst_ls", int'(vb.line_start), 0);
        check("rst_fs", int'(vb.frame_start), 0);
        check("rst_hs", int'(vb.hSync), 0);
        check("rst_vs", int'(vb.vSync), 0);

        first_pe_after_release("rel");

        // Run to the last pixel of line 0, then take the wrap.
        n = 0;
        do begin
            tick();
            n++;
        end while (!(vb.pix_en && vb.hCount == 10'd799) && n < 4000);
        check("reach_h799", int'(vb.hCount), 799);
        check("h799_ls", int'(vb.line_start), 0);
        next_pe(n);
        check("wrap_h", int'(vb.hCount), 0);
        check("wrap_v", int'(vb.vCount), 1);
        check("wrap_ls", int'(vb.line_start), 1);
        check("wrap_fs", int'(vb.frame_start), 0);
        check("wrap_hs", int'(vb.hSync), 0);
        check("wrap_vs", int'(vb.vSync), 0);
        tick();
        check("ls_width", int'(vb.line_start), 0);

        // One full line, line_start to line_start.
        hs_lo = 1;
        pe_cnt = 1;
        br_cnt = 0;
        n = 1;
        while (n < 4000) begin
            tick();
            n++;
            if (vb.line_start) break;
            if (vb.pix_en) pe_cnt++;
            if (vb.pix_en && !vb.hSync) hs_lo++;
            if (vb.bright) br_cnt++;
        end
        check("line_clk", n, 3200);
        check("line_pe", pe_cnt, 800);
        check("hsync_low", hs_lo, 96);
        check("line1_bright", br_cnt, 0);
        check("line2_v", int'(vb.vCount), 2);
        check("line2_vs_rise", int'(vb.vSync), 1);

        // Asynchronous reset mid-line, checked before any clk edge.
        n = 0;
        do begin
            tick();
            n++;
        end while (!(vb.pix_en && vb.hCount == 10'd400) && n < 4000);
        check("reach_h400", int'(vb.hCount), 400);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_h", int'(vb.hCount), 0);
        check("mid_rst_v", int'(vb.vCount), 0);
        check("mid_rst_hs", int'(vb.hSync), 0);
        check("mid_rst_vs", int'(vb.vSync), 0);
        repeat (3) @(posedge clk);
        first_pe_after_release("mid");

        // Small raster, CLK_DIV=1: 20x10 counts, frame = 200 clk.
        @(negedge clk);
        rst_s = 1'b1;
        tick();
        check("s_first_pe", int'(vs.pix_en), 1);
        check("s_first_h", int'(vs.hCount), 1);
        n = 1;
        pe_zero = 0;
        while (!vs.frame_start && n < 1000) begin
            tick();
            n++;
            if (!vs.pix_en) pe_zero++;
        end
        check("s_first_fs_edge", n, 200);
        check("s_fs_h", int'(vs.hCount), 0);
        check("s_fs_v", int'(vs.vCount), 0);
        check("s_fs_ls", int'(vs.line_start), 1);

        br_cnt = 0;
        vs_lo = 0;
        hs_lo = 0;
        ls_cnt = 0;
        bpt = 8'h00;
        hpt = 2'b00;
        n = 0;
        do begin
            if (vs.bright) br_cnt++;
            if (!vs.vSync) vs_lo++;
            if (!vs.hSync) hs_lo++;
            if (vs.line_start) ls_cnt++;
            if (!vs.pix_en) pe_zero++;
            if (vs.hCount == 10'd4 && vs.vCount == 10'd3) bpt[0] = vs.bright;
            if (vs.hCount == 10'd5 && vs.vCount == 10'd3) bpt[1] = vs.bright;
            if (vs.hCount == 10'd16 && vs.vCount == 10'd7) bpt[2] = vs.bright;
            if (vs.hCount == 10'd17 && vs.vCount == 10'd7) bpt[3] = vs.bright;
            if (vs.hCount == 10'd10 && vs.vCount == 10'd2) bpt[4] = vs.bright;
            if (vs.hCount == 10'd10 && vs.vCount == 10'd8) bpt[5] = vs.bright;
            if (vs.hCount == 10'd2 && vs.vCount == 10'd5) hpt[0] = vs.hSync;
            if (vs.hCount == 10'd3 && vs.vCount == 10'd5) hpt[1] = vs.hSync;
            tick();
            n++;
        end while (!vs.frame_start && n < 1000);
        check("s_frame_clk", n, 200);
        check("s_pe_zero", pe_zero, 0);
        check("s_bright_cnt", br_cnt, 60);
        check("s_vsync_low", vs_lo, 40);
        check("s_hsync_low", hs_lo, 30);
        check("s_lines", ls_cnt, 10);
        check("s_bright_pts", int'(bpt), 8'b0000_0110);
        check("s_hsync_edge", int'(hpt), 2'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
